ordenador_serial: RTL and testbench
===================================

ORDENADOR_SERIAL -- requirements
Module: ordenador_serial

Interface
REQ-001 SHALL have parameter N, default 9, number of values per frame.
REQ-002 SHALL have parameter W, default 4, bit width of each value.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  W  unsigned value to be sorted.
REQ-008 out_valid  output  1  out_data holds a sorted value.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  W  current sorted value, ascending order.
REQ-011 out_last  output  1  high with the N-th (largest) value of a frame.

Function
REQ-012 Transfer occurs on a cycle with valid && ready on that port; no other cycle transfers.
REQ-013 FSM SHALL have two states: LOAD, which collects values, and SEND, which emits them.
REQ-014 LOAD: in_ready=1, out_valid=0; SEND: in_ready=0, out_valid=1.
REQ-015 Each accepted value SHALL be inserted into ascending register array r[0..N-1] in the same cycle, using parallel compare-and-shift.
REQ-016 Insertion position = count of stored entries <= new value; equal values keep arrival order; entries at and above the position shift up by one.
REQ-017 Fill counter cnt (0..N-1) SHALL increment per accepted value; on acceptance with cnt=N-1, the FSM SHALL go to SEND and clear cnt to 0.
REQ-018 Latency: out_valid SHALL be high the cycle after the N-th input transfer, with out_data=r[0].
REQ-019 SEND: out_data=r[idx]; idx increments per output transfer; out_last=1 only when idx=N-1.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_last and idx SHALL hold unchanged.
REQ-021 On the transfer with out_last=1, the FSM SHALL return to LOAD, clear idx, and assert in_ready the next cycle; array contents may be stale, but they are overwritten by the valid-count rule.
REQ-022 in_valid in SEND SHALL be ignored; out_ready in LOAD SHALL be ignored.
REQ-023 Comparison SHALL be unsigned, W bits, with no widening; the full range 0..2^W-1 is legal.

Reset
REQ-024 Asserting rst_n low SHALL, asynchronously: set state to LOAD, cnt=0, idx=0, r[*]=0, out_valid=0, out_last=0, out_data=0.
REQ-025 in_ready SHALL be 1 on the first clock after rst_n deasserts.
REQ-026 Reset mid-frame, in LOAD or SEND, SHALL discard the partial frame; no value from it is ever emitted.

Structure
REQ-027 Shared package ordenador_pkg SHALL hold N_DEF=9, W_DEF=4, and the state enum {LOAD, SEND}.
REQ-028 One sub-module, ordenador_celula, SHALL implement one array slot: inputs are own value, lower neighbour, new value, slot-valid and lower-valid; output is next value. It is instantiated N times.
REQ-029 Design SHALL be fully synchronous apart from the reset; there SHALL be no combinational path from in_valid to out_valid.

Verification
REQ-030 Input 9,3,7,1,8,2,6,4,5 with out_ready=1 -> out 1,2,3,4,5,6,7,8,9 on consecutive cycles starting 1 cycle after the 9th input; out_last only with 9.
REQ-031 Input 15,14,13,12,11,10,9,8,7 (descending) -> out 7..15; input 5 x9 -> out 5 x9, out_last on the 9th.
REQ-032 Same frame with out_ready=0 for 3 cycles after the second output -> out_data stays 2 for 3 cycles, then 3..9 follow; no value is lost or duplicated.
REQ-033 rst_n low after 4 inputs, then a full frame 0,0,15,15,8,8,1,1,4 -> out 0,0,1,1,4,8,8,15,15; none of the 4 pre-reset values appear.
REQ-034 Two back-to-back frames with in_valid held high -> in_ready=0 throughout SEND; the second frame is accepted from the cycle after the first out_last transfer, and each frame is sorted independently.

Source files
------------

// File: rtl/ordenador_pkg.sv
// Shared definitions for the serial insertion sorter: default frame geometry and FSM states.
package ordenador_pkg;

  localparam int N_DEF = 9;
  localparam int W_DEF = 4;

  typedef enum logic {
    LOAD = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/ordenador_celula.sv
// One slot of the sorted register array: decides whether the slot keeps its value,
// takes the incoming value, or inherits its lower neighbour's value (shift up).
module ordenador_celula
  import ordenador_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] own,
  input  logic [W-1:0] lower,
  input  logic [W-1:0] new_value,
  input  logic         own_valid,
  input  logic         lower_valid,
  output logic [W-1:0] next_value
);

  logic own_le;
  logic lower_le;

  // "<=" places a new value after any equal stored values, preserving arrival order.
  assign own_le   = own_valid && (own <= new_value);
  assign lower_le = lower_valid && (lower <= new_value);

  always_comb begin
    next_value = lower;
    if (own_le) begin
      next_value = own;
    end else if (lower_le) begin
      next_value = new_value;
    end
  end

endmodule

// File: rtl/ordenador_serial.sv
// Streaming insertion sorter: collects N values into an ascending array, then emits
// them smallest-first with a valid/ready handshake on both sides.
module ordenador_serial
  import ordenador_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  idx;
  logic [CW-1:0]  idx_inc;
  logic [W-1:0]   r      [N];
  logic [W-1:0]   r_next [N];
  logic [N-1:0]   slot_valid;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == SEND);
  assign idx_inc   = idx + 1'b1;

  // Slots at or above cnt are treated as empty, so stale data from a previous frame never matters.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign slot_valid[gi] = (cnt > CW'(gi));
    if (gi == 0) begin : g_bottom
      ordenador_celula #(.W(W)) u_cell (
        .own        (r[0]),
        .lower      ({W{1'b0}}),
        .new_value  (in_data),
        .own_valid  (slot_valid[0]),
        .lower_valid(1'b1),
        .next_value (r_next[0])
      );
    end else begin : g_upper
      ordenador_celula #(.W(W)) u_cell (
        .own        (r[gi]),
        .lower      (r[gi-1]),
        .new_value  (in_data),
        .own_valid  (slot_valid[gi]),
        .lower_valid(slot_valid[gi-1]),
        .next_value (r_next[gi])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= '0;
      idx      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      for (int i = 0; i < N; i++) r[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) r[i] <= r_next[i];
            if (cnt == CW'(N - 1)) begin
              state    <= SEND;
              cnt      <= '0;
              idx      <= '0;
              // Present the minimum of the just-completed array on the very next cycle.
              out_data <= r_next[0];
              out_last <= (N == 1);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state    <= LOAD;
              idx      <= '0;
              out_last <= 1'b0;
            end else begin
              idx      <= idx_inc;
              out_data <= r[idx_inc];
              out_last <= (idx_inc == CW'(N - 1));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ordenador_serial.sv
// Directed bench for ordenador_serial: a frame-level sorting model checked every cycle,
// plus literal expectations for the emitted sequences.
module tb_ordenador_serial;
  import ordenador_pkg::*;

  localparam int N = N_DEF;
  localparam int W = W_DEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ordenador_serial #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: gather N accepted values, sort them, then walk the sorted list.
  int  frame_q[$];
  int  exp_sorted[N];
  bit  m_load = 1'b1;
  int  m_idx  = 0;
  int  out_log[$];

  function automatic void sort_frame();
    int tmp[N];
    for (int i = 0; i < N; i++) tmp[i] = frame_q[i];
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0 && tmp[j-1] > tmp[j]; j--) begin
        int t = tmp[j];
        tmp[j] = tmp[j-1];
        tmp[j-1] = t;
      end
    exp_sorted = tmp;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q.delete();
      m_load = 1'b1;
      m_idx  = 0;
    end else if (m_load) begin
      if (in_valid) begin
        frame_q.push_back(int'(in_data));
        if (frame_q.size() == N) begin
          sort_frame();
          frame_q.delete();
          m_load = 1'b0;
          m_idx  = 0;
        end
      end
    end else if (out_ready) begin
      if (m_idx == N - 1) begin
        m_load = 1'b1;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
  end

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) out_log.push_back(int'(out_data));

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(m_load));
    chk("out_valid", int'(out_valid), int'(!m_load));
    if (!rst_n) begin
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
    end else if (!m_load) begin
      chk("out_data", int'(out_data), exp_sorted[m_idx]);
      chk("out_last", int'(out_last), int'(m_idx == N - 1));
    end
  end

  task automatic push(input int v);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = W'(v);
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("push_accept", int'(acc), 1);
  endtask

  task automatic push_frame(input int f[N], input bit keep_valid);
    for (int i = 0; i < N; i++) push(f[i]);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = out_valid && out_ready && out_last;
      @(posedge clk);
      #1;
    end
    chk("drain_done", int'(done), 1);
  endtask

  task automatic check_log(input string nm, input int e[N]);
    chk({nm, "_len"}, int'(out_log.size() >= N), 1);
    if (out_log.size() >= N)
      for (int i = 0; i < N; i++) chk(nm, out_log.pop_front(), e[i]);
  endtask

  int f_mix[N]   = '{9, 3, 7, 1, 8, 2, 6, 4, 5};
  int e_mix[N]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int f_desc[N]  = '{15, 14, 13, 12, 11, 10, 9, 8, 7};
  int e_desc[N]  = '{7, 8, 9, 10, 11, 12, 13, 14, 15};
  int f_same[N]  = '{5, 5, 5, 5, 5, 5, 5, 5, 5};
  int f_edge[N]  = '{0, 0, 15, 15, 8, 8, 1, 1, 4};
  int e_edge[N]  = '{0, 0, 1, 1, 4, 8, 8, 15, 15};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready), 1);
    @(posedge clk); #1;

    // Mixed frame, continuous drain; first output one cycle after the last input.
    push_frame(f_mix, 1'b0);
    @(negedge clk);
    chk("latency_valid", int'(out_valid), 1);
    chk("latency_first", int'(out_data), 1);
    drain();
    check_log("mix", e_mix);

    push_frame(f_desc, 1'b0);
    drain();
    check_log("desc", e_desc);

    push_frame(f_same, 1'b0);
    drain();
    check_log("equal", f_same);

    // Back-pressure after the first output: value 2 must hold.
    push_frame(f_mix, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", int'(out_data), 2);
      chk("stall_last", int'(out_last), 0);
    end
    out_ready = 1'b1;
    drain();
    check_log("stall", e_mix);

    // Reset part-way through loading.
    for (int i = 0; i < 4; i++) push(f_desc[i]);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_log.delete();
    push_frame(f_edge, 1'b0);
    drain();
    check_log("reset_load", e_edge);

    // Reset part-way through sending.
    push_frame(f_desc, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_log.delete();
    push_frame(f_same, 1'b0);
    drain();
    check_log("reset_send", f_same);

    // Back-to-back frames with in_valid held high across SEND.
    push_frame(f_mix, 1'b1);
    push_frame(f_edge, 1'b0);
    drain();
    check_log("b2b_first", e_mix);
    check_log("b2b_second", e_edge);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
